bios_select_ctrl: RTL and testbench



---
 rtl/bios_ctrl_pkg.sv | 31 +++
 rtl/bios_edge_sync.sv | 32 +++
 rtl/bios_select_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_bios_select_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bios_ctrl_pkg.sv
// Shared types and constants for the BIOS flash selector: FSM states,
// BiosStatus field positions and the flash index width.
package bios_ctrl_pkg;

    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BOOT = 2'd1,
        ST_RUN  = 2'd2
    } boot_state_t;

    localparam int STAT_ACTIVE_LSB  = 0;
    localparam int STAT_NEXT_LSB    = 3;
    localparam int STAT_CURRENT_LSB = 6;
    localparam int STAT_FAIL_LSB    = 9;
    localparam int STAT_LOCK_BIT    = 11;
    localparam int STAT_BOOTOK_BIT  = 12;

    // Successor socket in rotation order; the result never equals idx for n >= 2.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx,
                                                  input logic [3:0]       n);
        logic [3:0] sum;
        sum = {1'b0, idx} + 4'd1;
        if (sum >= n) begin
            sum = 4'd0;
        end
        return sum[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/bios_edge_sync.sv
// Two-flop synchroniser plus a history flop producing single-cycle rise/fall pulses.
// Latency: level valid 2 edges after the input changes, pulses act on the 3rd edge.
module bios_edge_sync (
    input  logic LpcClock,
    input  logic ResetN,
    input  logic sig,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge LpcClock or negedge ResetN) begin
        if (!ResetN) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= sig;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;

endmodule

// File: rtl/bios_select_ctrl.sv
// BIOS flash socket selector: boot-failure counting, automatic/forced image rotation
// and an LPC register override. Optional BIOS_LOCK_EN adds a write-once lock bit.
module bios_select_ctrl
    import bios_ctrl_pkg::*;
#(
    parameter int         NUM_BIOS  = 2,
    parameter logic [7:0] REG_ADDR  = 8'h04,
    parameter int         RETRY_MAX = 2
) (
    input  logic                LpcClock,
    input  logic                ResetN,
    input  logic                MainReset,
    input  logic                BootDone,
    input  logic                Write,
    input  logic [7:0]          RegAddress,
    input  logic [7:0]          DataWr,
    input  logic                BiosCS,
    input  logic                BIOS_SEL,
    input  logic                SwapDisable,
    input  logic                ForceSwap,
    output logic [NUM_BIOS-1:0] BIOS,
    output logic [15:0]         BiosStatus
);

    localparam logic [3:0] NB = 4'(NUM_BIOS);
    localparam logic [2:0] RM = 3'(RETRY_MAX);

    logic mrst_lvl, mrst_rise, mrst_fall;
    logic bd_lvl, bd_rise, bd_fall;

    bios_edge_sync u_mrst_sync (
        .LpcClock (LpcClock),
        .ResetN   (ResetN),
        .sig      (MainReset),
        .level    (mrst_lvl),
        .rise     (mrst_rise),
        .fall     (mrst_fall)
    );

    bios_edge_sync u_bd_sync (
        .LpcClock (LpcClock),
        .ResetN   (ResetN),
        .sig      (BootDone),
        .level    (bd_lvl),
        .rise     (bd_rise),
        .fall     (bd_fall)
    );

    boot_state_t      state, state_nxt;
    logic [IDX_W-1:0] act_idx, act_nxt;
    logic [IDX_W-1:0] next_idx, next_nxt;
    logic [IDX_W-1:0] cur_idx, cur_nxt;
    logic [1:0]       fail_cnt, fail_nxt;
    logic             pending, pending_nxt;
    logic             boot_ok, boot_ok_nxt;
    logic             lock;
    logic             wr_hit, wr_ok, swap;
    logic [2:0]       cnt_inc;

    assign wr_hit = Write && (RegAddress == REG_ADDR);

`ifdef BIOS_LOCK_EN
    always_ff @(posedge LpcClock or negedge ResetN) begin
        if (!ResetN) begin
            lock <= 1'b0;
        end else if (wr_ok && DataWr[7]) begin
            lock <= 1'b1;
        end
    end
    assign wr_ok = wr_hit && !lock;
`else
    assign lock  = 1'b0;
    assign wr_ok = wr_hit;
`endif

    always_ff @(posedge LpcClock or negedge ResetN) begin
        if (!ResetN) begin
            state    <= ST_IDLE;
            act_idx  <= '0;
            next_idx <= IDX_W'(1);
            cur_idx  <= '0;
            fail_cnt <= '0;
            pending  <= 1'b0;
            boot_ok  <= 1'b0;
        end else begin
            state    <= state_nxt;
            act_idx  <= act_nxt;
            next_idx <= next_nxt;
            cur_idx  <= cur_nxt;
            fail_cnt <= fail_nxt;
            pending  <= pending_nxt;
            boot_ok  <= boot_ok_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        act_nxt     = act_idx;
        next_nxt    = next_idx;
        cur_nxt     = cur_idx;
        fail_nxt    = fail_cnt;
        pending_nxt = pending;
        boot_ok_nxt = boot_ok;
        swap        = 1'b0;
        cnt_inc     = {1'b0, fail_cnt} + 3'd1;

        if (mrst_rise) begin
            boot_ok_nxt = 1'b0;
            if (pending && !SwapDisable) begin
                swap        = 1'b1;
                cur_nxt     = next_idx;
                act_nxt     = next_idx;
                next_nxt    = wrap_inc(next_idx, NB);
                pending_nxt = 1'b0;
                fail_nxt    = '0;
            end
        end

        case (state)
            ST_IDLE: begin
                if (mrst_rise) begin
                    state_nxt = SwapDisable ? ST_RUN : ST_BOOT;
                end
            end
            ST_BOOT: begin
                if (bd_lvl) begin
                    state_nxt   = ST_RUN;
                    boot_ok_nxt = 1'b1;
                    fail_nxt    = '0;
                end else if (mrst_fall) begin
                    state_nxt = ST_IDLE;
                    // Without the jumper the count parks at the limit instead of swapping.
                    if (cnt_inc >= RM) begin
                        if (BIOS_SEL) begin
                            pending_nxt = 1'b1;
                            fail_nxt    = '0;
                        end else begin
                            fail_nxt = RM[1:0];
                        end
                    end else begin
                        fail_nxt = cnt_inc[1:0];
                    end
                end
            end
            ST_RUN: begin
                if (mrst_fall) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (ForceSwap) begin
            pending_nxt = 1'b1;
        end

        // A swap on the same edge owns Active/Next; the software write is dropped.
        if (wr_ok && !swap) begin
            if ({1'b0, DataWr[2:0]} < NB) begin
                act_nxt = DataWr[2:0];
            end
            if ({1'b0, DataWr[5:3]} < NB) begin
                next_nxt = DataWr[5:3];
            end
        end
    end

    always_comb begin
        BIOS = '1;
        for (int i = 0; i < NUM_BIOS; i++) begin
            BIOS[i] = (act_idx == IDX_W'(i)) ? BiosCS : 1'b1;
        end
    end

    always_comb begin
        BiosStatus = '0;
        BiosStatus[STAT_ACTIVE_LSB  +: IDX_W] = act_idx;
        BiosStatus[STAT_NEXT_LSB    +: IDX_W] = next_idx;
        BiosStatus[STAT_CURRENT_LSB +: IDX_W] = cur_idx;
        BiosStatus[STAT_FAIL_LSB    +: 2]     = fail_cnt;
        BiosStatus[STAT_LOCK_BIT]             = lock;
        BiosStatus[STAT_BOOTOK_BIT]           = boot_ok;
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, mrst_lvl, bd_rise, bd_fall, DataWr[7:6]};

endmodule

// File: tb/tb_bios_select_ctrl.sv
// Randomized scoreboard bench for bios_select_ctrl with NUM_BIOS=3, RETRY_MAX=2.
module tb_bios_select_ctrl;

    localparam int         NB = 3;
    localparam int         RM = 2;
    localparam logic [7:0] RA = 8'h04;

    logic          LpcClock = 1'b0;
    logic          ResetN = 1'b0;
    logic          MainReset = 1'b0;
    logic          BootDone = 1'b0;
    logic          Write = 1'b0;
    logic [7:0]    RegAddress = 8'h00;
    logic [7:0]    DataWr = 8'h00;
    logic          BiosCS = 1'b1;
    logic          BIOS_SEL = 1'b1;
    logic          SwapDisable = 1'b0;
    logic          ForceSwap = 1'b0;
    logic [NB-1:0] BIOS;
    logic [15:0]   BiosStatus;

    bios_select_ctrl #(.NUM_BIOS(NB), .REG_ADDR(RA), .RETRY_MAX(RM)) dut (
        .LpcClock    (LpcClock),
        .ResetN      (ResetN),
        .MainReset   (MainReset),
        .BootDone    (BootDone),
        .Write       (Write),
        .RegAddress  (RegAddress),
        .DataWr      (DataWr),
        .BiosCS      (BiosCS),
        .BIOS_SEL    (BIOS_SEL),
        .SwapDisable (SwapDisable),
        .ForceSwap   (ForceSwap),
        .BIOS        (BIOS),
        .BiosStatus  (BiosStatus)
    );

    always #15 LpcClock = ~LpcClock;

    int checks = 0;
    int failures = 0;

    // Reference model of the selector's architectural state.
    int    m_act, m_nxt, m_cur, m_fail, m_pend, m_ok, m_lock;
    string m_st;

    logic [15:0]   exp_stat_q[$];
    logic [NB-1:0] exp_bios_q[$];
    string         tag_q[$];
    logic          obs = 1'b0;

    function automatic logic [15:0] m_status();
        return 16'((m_ok << 12) | (m_lock << 11) | (m_fail << 9) |
                   (m_cur << 6) | (m_nxt << 3) | m_act);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge LpcClock);
        #1;
    endtask

    task automatic model_reset();
        m_act = 0; m_nxt = 1; m_cur = 0; m_fail = 0;
        m_pend = 0; m_ok = 0; m_lock = 0; m_st = "IDLE";
    endtask

    task automatic observe(input string tag);
        logic [NB-1:0] eb;
        BiosCS = 1'($urandom_range(0, 1));
        for (int i = 0; i < NB; i++) eb[i] = (i == m_act) ? BiosCS : 1'b1;
        exp_stat_q.push_back(m_status());
        exp_bios_q.push_back(eb);
        tag_q.push_back(tag);
        obs = 1'b1;
        tick(1);
        obs = 1'b0;
    endtask

    // Release-time rules; returns whether an image swap happened.
    function automatic bit model_release();
        bit swapped;
        swapped = (m_pend != 0) && !SwapDisable;
        m_ok = 0;
        if (swapped) begin
            m_cur  = m_nxt;
            m_act  = m_nxt;
            m_nxt  = (m_nxt + 1) % NB;
            m_pend = 0;
            m_fail = 0;
        end
        if (m_st == "IDLE") m_st = SwapDisable ? "RUN" : "BOOT";
        if (m_st == "BOOT" && BootDone) begin
            m_st = "RUN"; m_ok = 1; m_fail = 0;
        end
        return swapped;
    endfunction

    function automatic void model_write(input logic [7:0] addr, input logic [7:0] data);
        if (addr == RA && m_lock == 0) begin
            if (int'(data[2:0]) < NB) m_act = int'(data[2:0]);
            if (int'(data[5:3]) < NB) m_nxt = int'(data[5:3]);
`ifdef BIOS_LOCK_EN
            if (data[7]) m_lock = 1;
`endif
        end
    endfunction

    task automatic do_release();
        bit s;
        MainReset = 1'b1;
        s = model_release();
        tick(6);
    endtask

    task automatic do_fall();
        MainReset = 1'b0;
        if (m_st == "BOOT") begin
            if (m_fail + 1 >= RM) begin
                if (BIOS_SEL) begin m_pend = 1; m_fail = 0; end
                else m_fail = RM;
            end else begin
                m_fail = m_fail + 1;
            end
        end
        m_st = "IDLE";
        tick(6);
    endtask

    task automatic do_bootdone();
        BootDone = ~BootDone;
        if (BootDone && m_st == "BOOT") begin
            m_st = "RUN"; m_ok = 1; m_fail = 0;
        end
        tick(6);
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
        Write = 1'b1; RegAddress = addr; DataWr = data;
        tick(1);
        Write = 1'b0;
        model_write(addr, data);
        tick(3);
    endtask

    task automatic do_force();
        ForceSwap = 1'b1;
        tick(1);
        ForceSwap = 1'b0;
        m_pend = 1;
        tick(3);
    endtask

    task automatic do_reset();
        MainReset = 1'b0; BootDone = 1'b0; ResetN = 1'b0;
        tick(2);
        ResetN = 1'b1;
        model_reset();
        tick(3);
    endtask

    // Release with a register write landing on the edge the release acts on.
    task automatic do_collision(input logic [7:0] data);
        bit s;
        MainReset = 1'b1;
        tick(2);
        Write = 1'b1; RegAddress = RA; DataWr = data;
        tick(1);
        Write = 1'b0;
        s = model_release();
        if (!s) model_write(RA, data);
        tick(5);
    endtask

    always @(negedge LpcClock) begin
        if (obs) begin
            if (exp_stat_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL scoreboard_underflow got=%h required=entry", BiosStatus);
            end else begin
                automatic string         tg = tag_q.pop_front();
                automatic logic [15:0]   es = exp_stat_q.pop_front();
                automatic logic [NB-1:0] eb = exp_bios_q.pop_front();
                checks++;
                if (BiosStatus !== es) begin
                    failures++;
                    $display("FAIL %s_status got=%h required=%h", tg, BiosStatus, es);
                end
                checks++;
                if (BIOS !== eb) begin
                    failures++;
                    $display("FAIL %s_bios got=%b required=%b", tg, BIOS, eb);
                end
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL timeout got=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        tick(3);
        ResetN = 1'b1;
        tick(3);
        observe("reset");

        // Two failed boots then a release rotates to socket 1.
        BIOS_SEL = 1'b1; SwapDisable = 1'b0;
        do_release(); observe("rot_boot1");
        do_fall();    observe("rot_fail1");
        do_release();
        do_fall();    observe("rot_pending");
        do_release(); observe("rot_swap");

        // Successful boot sets BootOk without counting.
        do_reset();
        do_release();
        do_bootdone(); observe("ok_first");
        do_fall();
        do_release(); observe("ok_second");
        do_bootdone();

        // Forced swap deferred while swaps are disabled.
        do_reset();
        SwapDisable = 1'b1;
        do_force();
        do_release(); observe("force_held");
        do_fall();
        SwapDisable = 1'b0;
        do_release(); observe("force_swap");

        // Register writes: per-field range filter, wrong address, swap collision.
        do_reset();
        do_write(RA, 8'h12);    observe("wr_both");
        do_write(RA, 8'h0B);    observe("wr_drop_act");
        do_write(8'h05, 8'h00); observe("wr_wrong_addr");
        do_force();
        do_collision(8'h0B);    observe("wr_collision");

`ifdef BIOS_LOCK_EN
        do_reset();
        do_write(RA, 8'h81); observe("lock_set");
        do_write(RA, 8'h00); observe("lock_ignored");
        do_reset();          observe("lock_reset");
`endif

        do_reset();
        for (int k = 0; k < 250; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: if (MainReset) do_fall(); else do_release();
                3:       do_bootdone();
                4, 5:    do_write($urandom_range(0, 1) ? RA : 8'($urandom), 8'($urandom));
                6:       do_force();
                7:       begin SwapDisable = ~SwapDisable; tick(2); end
                8:       begin BIOS_SEL = ~BIOS_SEL; tick(2); end
                default: if ($urandom_range(0, 7) == 0) do_reset();
                         else do_write(RA, 8'($urandom));
            endcase
            observe("rand");
        end

        tick(3);
        checks++;
        if (exp_stat_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d required=0", exp_stat_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
